// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter.
//   - mem_size_e : RV32 access size encoding on the requester ports
//   - rsp_ctx_t  : everything needed one cycle after accept to build a response
//   - access_err : alignment / legal-size check for one access
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DATA_BYTES = 4;
    localparam int NREQ       = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_e;

    typedef struct packed {
        logic      port;
        logic [1:0] off;
        mem_size_e size;
        logic      uns;
        logic      we;
        logic      err;
    } rsp_ctx_t;

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic access_err(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = off[0];
            SZ_WORD: access_err = (off != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane alignment, one instance per direction.
//   LOAD=0 (store side): o_data = store data replicated across lanes,
//                        o_lanes = byte write enables for the access.
//   LOAD=1 (load side) : o_data = memory word shifted down by the byte offset
//                        and sign/zero-extended to the access size,
//                        o_lanes = byte lanes the load consumes.
// Ports:
//   i_off   byte offset within the word      i_size  access size (mem_size_e)
//   i_uns   zero-extend loads when 1         i_data  store data or memory word
//   o_data  aligned data                     o_lanes byte-lane mask
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter bit LOAD = 1'b0
) (
    input  logic [1:0]            i_off,
    input  logic [1:0]            i_size,
    input  logic                  i_uns,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_BYTES-1:0] o_lanes
);

    mem_size_e w_size;
    assign w_size = mem_size_e'(i_size);

    // Misaligned shifts may fall off the top of the mask; the caller
    // suppresses those accesses anyway.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        o_lanes = '0;
        case (w_size)
            SZ_BYTE: o_lanes = 4'b0001 << i_off;
            SZ_HALF: o_lanes = 4'b0011 << i_off;
            SZ_WORD: o_lanes = 4'b1111;
            default: o_lanes = '0;
        endcase
    end

    generate
        if (LOAD) begin : g_load
            logic [DATA_WIDTH-1:0] w_shifted;
            assign w_shifted = i_data >> {i_off, 3'b000};

            always_comb begin
                o_data = w_shifted;
                case (w_size)
                    SZ_BYTE: o_data = {{24{~i_uns & w_shifted[7]}},  w_shifted[7:0]};
                    SZ_HALF: o_data = {{16{~i_uns & w_shifted[15]}}, w_shifted[15:0]};
                    default: o_data = w_shifted;
                endcase
            end
        end else begin : g_store
            // Extension does not apply to stores.
            logic w_unused_uns;
            assign w_unused_uns = i_uns;

            always_comb begin
                o_data = i_data;
                case (w_size)
                    SZ_BYTE: o_data = {4{i_data[7:0]}};
                    SZ_HALF: o_data = {2{i_data[15:0]}};
                    default: o_data = i_data;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous single-port data memory (1-cycle read latency,
// write-first, byte write enables) between port 0 (core LSU) and port 1
// (debug/DMA). One access is accepted every cycle any request is valid; its
// response pulses on the owning port exactly one cycle later.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a collision
//                           undefined -> round-robin between the ports
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_req_*           per-port request (valid, byte addr, we, size, unsigned, wdata)
//   o_req_ready       one-hot accept for the granted port
//   o_rsp_valid       one-hot response pulse, one cycle after accept
//   o_rsp_rdata       extended load data (0 for stores and errors)
//   o_rsp_err         misaligned or illegal-size access
//   o_mem_*           word address, replicated write data, byte write enables
//   i_mem_rdata       memory read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int BADDR_WIDTH = ADDR_WIDTH + 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             i_req_valid,
    output logic [NREQ-1:0]             o_req_ready,
    input  logic [NREQ*BADDR_WIDTH-1:0] i_req_addr,
    input  logic [NREQ-1:0]             i_req_we,
    input  logic [NREQ*2-1:0]           i_req_size,
    input  logic [NREQ-1:0]             i_req_unsigned,
    input  logic [NREQ*DATA_WIDTH-1:0]  i_req_wdata,
    output logic [NREQ-1:0]             o_rsp_valid,
    output logic [DATA_WIDTH-1:0]       o_rsp_rdata,
    output logic                        o_rsp_err,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic [DATA_WIDTH-1:0]       o_mem_wdata,
    output logic [DATA_BYTES-1:0]       o_mem_wen,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata
);

    // ---------------------------------------------------------------- grant
    logic w_any;
    logic w_gnt;
    assign w_any = |i_req_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_gnt = ~i_req_valid[0];
`else
    // r_rr names the port that wins the next collision.
    logic r_rr;
    assign w_gnt = (&i_req_valid) ? r_rr : i_req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (w_any) begin
            r_rr <= ~w_gnt;
        end
    end
`endif

    assign o_req_ready = w_any ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    // ------------------------------------------------- granted request mux
    logic [BADDR_WIDTH-1:0] w_addr;
    logic [1:0]             w_size_raw;
    logic                   w_we;
    logic                   w_uns;
    logic [DATA_WIDTH-1:0]  w_wdata;
    logic [1:0]             w_off;
    logic                   w_err;
    logic [DATA_BYTES-1:0]  w_st_lanes;

    assign w_addr     = w_gnt ? i_req_addr[2*BADDR_WIDTH-1:BADDR_WIDTH] : i_req_addr[BADDR_WIDTH-1:0];
    assign w_size_raw = w_gnt ? i_req_size[3:2] : i_req_size[1:0];
    assign w_we       = w_gnt ? i_req_we[1] : i_req_we[0];
    assign w_uns      = w_gnt ? i_req_unsigned[1] : i_req_unsigned[0];
    assign w_wdata    = w_gnt ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_wdata[DATA_WIDTH-1:0];
    assign w_off      = w_addr[1:0];
    assign w_err      = access_err(mem_size_e'(w_size_raw), w_off);

    dmem_lane_align #(.LOAD(1'b0)) u_store_align (
        .i_off   (w_off),
        .i_size  (w_size_raw),
        .i_uns   (w_uns),
        .i_data  (w_wdata),
        .o_data  (o_mem_wdata),
        .o_lanes (w_st_lanes)
    );

    assign o_mem_addr = w_addr[BADDR_WIDTH-1:2];
    // Faulting accesses are still accepted but must never touch memory.
    assign o_mem_wen  = (w_any && w_we && !w_err) ? w_st_lanes : '0;

    // --------------------------------------------------- response pipeline
    logic     r_pend;
    rsp_ctx_t r_ctx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
            r_ctx  <= '0;
        end else begin
            r_pend <= w_any;
            if (w_any) begin
                r_ctx <= '{port: w_gnt, off: w_off, size: mem_size_e'(w_size_raw),
                           uns: w_uns, we: w_we, err: w_err};
            end
        end
    end

    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [DATA_BYTES-1:0] w_unused_ld_lanes;

    dmem_lane_align #(.LOAD(1'b1)) u_load_align (
        .i_off   (r_ctx.off),
        .i_size  (r_ctx.size),
        .i_uns   (r_ctx.uns),
        .i_data  (i_mem_rdata),
        .o_data  (w_ld_data),
        .o_lanes (w_unused_ld_lanes)
    );

    assign o_rsp_valid = r_pend ? (r_ctx.port ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_err   = r_pend & r_ctx.err;
    assign o_rsp_rdata = (r_pend && !r_ctx.we && !r_ctx.err) ? w_ld_data : '0;

endmodule
